// File: rtl/calc_pkg.sv
// Shared calculator output-path definitions: default digit count, converter
// states and the display nibble codes used downstream of the converter.
package calc_pkg;

  localparam int unsigned DIGITS_DEFAULT = 10;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_e;

  // Non-decimal nibble codes for the placement stage and display decoder.
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] MINUS = 4'hE;

endpackage

// File: rtl/binary_to_bcd_if.sv
// Start/done handshake and result bus between the arithmetic unit side and
// the binary-to-BCD converter.
interface binary_to_bcd_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) ();

  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  signBit;
  logic [4*DIGITS-1:0]   BCD;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  signBit,
    input  BCD
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output signBit,
    output BCD
  );

endinterface

// File: rtl/binary_to_bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential signed binary to sign + BCD magnitude converter, one bit per
// clock (shift-and-add-3) under a start/done handshake.
module binary_to_bcd
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = calc_pkg::DIGITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  binary_to_bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if ((2.0 ** (WIDTH - 1)) > ((10.0 ** DIGITS) - 1.0)) begin : g_digits_check
    $error("binary_to_bcd: DIGITS too small for WIDTH");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mag_q;
  logic [BCD_W-1:0] bcd_q;
  logic             sign_q;
  logic [BCD_W-1:0] out_bcd_q;
  logic             out_sign_q;
  logic             done_q;

  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_shift;
  logic [WIDTH-1:0] mag_shift;
  logic [WIDTH-1:0] abs_value;
  logic             accept;
  logic             last_iter;
  logic             unused_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (bcd_q[4*g +: 4]),
      .corrected (bcd_corr[4*g +: 4])
    );
  end

  // The top corrected bit is always zero given the DIGITS/WIDTH constraint.
  assign unused_carry = bcd_corr[BCD_W-1];
  assign {bcd_shift, mag_shift} = {bcd_corr[BCD_W-2:0], mag_q, 1'b0};

  // Most-negative input wraps to 2^(WIDTH-1), which is the correct magnitude.
  assign abs_value = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (state_q == CONVERT) && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CONVERT;
      CONVERT: if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      out_bcd_q  <= '0;
      out_sign_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_iter;
      if (accept) begin
        sign_q <= bus.value[WIDTH-1];
        mag_q  <= abs_value;
        bcd_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == CONVERT) begin
        bcd_q <= bcd_shift;
        mag_q <= mag_shift;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_iter) begin
          out_bcd_q  <= bcd_shift;
          // No negative zero.
          out_sign_q <= sign_q && (|bcd_shift);
        end
      end
    end
  end

  assign bus.busy    = (state_q == CONVERT);
  assign bus.done    = done_q;
  assign bus.signBit = out_sign_q;
  assign bus.BCD     = out_bcd_q;

endmodule

// File: doc/binary_to_bcd.md
# binary_to_bcd

Sequential signed-binary to BCD converter in the calculator output path. It sits directly upstream of the sign/blanking placement stage. It takes the 32-bit two's-complement result from the arithmetic unit and produces a sign bit plus a 10-digit (40-bit) unsigned BCD magnitude. It uses shift-and-add-3 (double dabble), one bit per clock, under a start/done handshake.

## Interface
- WIDTH, 32: input binary width; also the number of conversion iterations.
- DIGITS, 10: BCD output digits. The constraint 2^(WIDTH-1) ≤ 10^DIGITS − 1 must hold; elaboration error otherwise.

- clk  input  1  rising-edge clock; one clock only
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of value; sampled only when idle
- value  input  WIDTH  two's-complement operand, sampled with start
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse: BCD/signBit just updated
- signBit  output  1  1 = negative result; feeds the placement stage
- BCD  output  4*DIGITS  unsigned BCD magnitude, digit 0 in [3:0]

## Operation
- Reset values: busy=0, done=0, signBit=0, BCD=0; state IDLE; internal registers cleared.
- States: IDLE, CONVERT.
  - IDLE→CONVERT on start=1.
  - CONVERT→IDLE after the WIDTH-th iteration.
- On acceptance:
  - Latch sign = value[WIDTH-1].
  - Latch magnitude = |value| as a WIDTH-bit unsigned number. The most-negative input (−2^(WIDTH-1)) yields magnitude 2^(WIDTH-1) via unsigned wrap; no overflow flag.
  - Clear the BCD shift register and the iteration counter (width $clog2(WIDTH+1)).
- Each CONVERT cycle:
  - Every digit ≥5 gets +3.
  - Then {bcd, mag} shifts left one bit; the MSB of mag enters bcd bit 0.
  - The counter increments.
- Final iteration:
  - Output registers BCD and signBit load the corrected/shifted result.
  - done=1 for exactly one cycle.
- Zero result forces signBit=0. There is no negative zero.
- BCD/signBit hold the last result until the next done; they do not change during conversion.
- start while busy=1 is ignored. No queueing and no error.
- Reset asserted mid-conversion aborts immediately to reset values. No done is produced.

## Timing
- start sampled high at edge E0 (state IDLE): busy=1 after E0.
- Iterations execute at edges E1..EWIDTH (32 for the default).
- After EWIDTH: BCD/signBit valid, done=1, busy=0.
- After EWIDTH+1: done=0.
- Latency: start edge to done = WIDTH clocks. Throughput: one conversion per WIDTH+1 clocks.
- Back-to-back: start held or reasserted in the done cycle is accepted at EWIDTH+1.
- value need only be stable at the accepting edge.

## Structure
- Shared package (calc_pkg) holds:
  - DIGITS default.
  - State enum {IDLE, CONVERT}.
  - Display nibble codes BLANK=4'hF and MINUS=4'hE, used by the downstream placement stage and the display decoder.
- Sub-module bcd_add3: combinational 4-bit digit correction (d≥5 ? d+3 : d), instantiated DIGITS times by generate.
- Top level holds the FSM, counter, shift register and output registers.

## Test plan
- Reset, then value=0, start: done after 32 clocks → signBit=0, BCD=40'h0000000000.
- value=12345 → signBit=0, BCD=40'h0000012345; busy high for exactly 32 cycles.
- value=−1 (32'hFFFFFFFF) → signBit=1, BCD=40'h0000000001. Also value=32'h80000000 → signBit=1, BCD=40'h2147483648.
- value=32'h7FFFFFFF → signBit=0, BCD=40'h2147483647. Pulse start with 999 on cycle 10 of that conversion → ignored; result is still 2147483647 and done pulses once.
- Start 4294 conversion, assert reset at cycle 15 → next cycle busy=0, done=0, BCD=0, signBit=0; no done follows.
- Back-to-back:
  - Start with 7.
  - In its done cycle, start with −250 → first result is BCD=...07, sign 0.
  - 32 clocks later, BCD=...0250, sign 1.
  - Previous result holds throughout the second conversion.
